// File: rtl/prmcu_uart_pkg.sv
// Shared types for the UART transmit-path arbiter: frame configuration layout
// and the arbiter state encoding.
package prmcu_uart_pkg;

    // Bit order matches the per-requester cfg slice {parity, stop[1:0], data[3:0]}.
    typedef struct packed {
        logic       n_parity_bits;
        logic [1:0] n_stop_bits;
        logic [3:0] n_data_bits;
    } uart_cfg_t;

    localparam int CFG_W = $bits(uart_cfg_t);

    localparam uart_cfg_t CFG_RESET = '{
        n_parity_bits: 1'b0,
        n_stop_bits:   2'd1,
        n_data_bits:   4'd8
    };

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WAIT_IDLE,
        SETTLE,
        XFER
    } arb_state_t;

endpackage

// File: rtl/prmcu_rr_arbiter.sv
// Combinational round-robin pick: the first requester after ptr (with wrap)
// that has req set wins.
module prmcu_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W:0]       start;
    logic [IDX_W:0]       pos;
    logic [IDX_W:0]       sum;
    logic [2*N_REQ-1:0]   doubled;
    logic [N_REQ-1:0]     rotated;

    // Rotating a doubled copy puts the search origin at bit 0.
    assign start   = (ptr == IDX_W'(N_REQ - 1)) ? '0 : ({1'b0, ptr} + 1'b1);
    assign doubled = {req, req};
    assign rotated = N_REQ'(doubled >> start);

    always_comb begin
        any = 1'b0;
        pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                any = 1'b1;
                pos = (IDX_W + 1)'(i);
            end
        end
    end

    always_comb begin
        sum = start + pos;
        if (sum >= (IDX_W + 1)'(N_REQ)) begin
            sum = sum - (IDX_W + 1)'(N_REQ);
        end
    end

    assign idx = IDX_W'(sum);
    assign gnt = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/prmcu_uart_tx_arbiter.sv
// Shares one UART transmit path among N_REQ requesters with round-robin, bounded
// bursts, and frame reconfiguration only while the transmitter is idle.
module prmcu_uart_tx_arbiter
    import prmcu_uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 8,
    parameter int DAT_W     = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ*DAT_W-1:0] req_dat_i,
    input  logic [N_REQ*CFG_W-1:0] req_cfg_i,
    input  logic [N_REQ-1:0]       req_vld_i,
    output logic [N_REQ-1:0]       req_rdy_o,
    output logic [N_REQ-1:0]       grant_o,
    output logic [DAT_W-1:0]       uart_in_dat_o,
    output logic                   uart_in_vld_o,
    input  logic                   uart_in_rdy_i,
    input  logic                   uart_tx_idle_i,
    output logic                   tx_en_o,
    output logic                   n_parity_bits_o,
    output logic [1:0]             n_stop_bits_o,
    output logic [3:0]             n_data_bits_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = 8;

    arb_state_t         state_reg, state_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
    uart_cfg_t          cfg_latched_reg, cfg_latched_next;
    uart_cfg_t          cfg_reg, cfg_next;
    logic               tx_en_reg;

    logic [DAT_W-1:0]   dat_arr [N_REQ];
    uart_cfg_t          cfg_arr [N_REQ];

    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               xfer_fire;
    logic               burst_last;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign dat_arr[gi] = req_dat_i[gi*DAT_W +: DAT_W];
            assign cfg_arr[gi] = uart_cfg_t'(req_cfg_i[gi*CFG_W +: CFG_W]);
        end
    endgenerate

    prmcu_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req (req_vld_i),
        .ptr (rr_ptr_reg),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign xfer_fire  = (state_reg == XFER) && req_vld_i[idx_reg] && uart_in_rdy_i;
    assign burst_last = ({1'b0, burst_cnt_reg} + 9'd1) == 9'(MAX_BURST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            idx_reg         <= '0;
            rr_ptr_reg      <= IDX_W'(N_REQ - 1);
            burst_cnt_reg   <= '0;
            cfg_latched_reg <= CFG_RESET;
            cfg_reg         <= CFG_RESET;
            tx_en_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            idx_reg         <= idx_next;
            rr_ptr_reg      <= rr_ptr_next;
            burst_cnt_reg   <= burst_cnt_next;
            cfg_latched_reg <= cfg_latched_next;
            cfg_reg         <= cfg_next;
            tx_en_reg       <= 1'b1;
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        idx_next         = idx_reg;
        rr_ptr_next      = rr_ptr_reg;
        burst_cnt_next   = burst_cnt_reg;
        cfg_latched_next = cfg_latched_reg;
        cfg_next         = cfg_reg;
        req_rdy_o        = '0;
        uart_in_vld_o    = 1'b0;
        uart_in_dat_o    = '0;

        case (state_reg)
            IDLE: begin
                if (|req_vld_i) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (arb_any) begin
                    grant_next       = arb_gnt;
                    idx_next         = arb_idx;
                    rr_ptr_next      = arb_idx;
                    cfg_latched_next = cfg_arr[arb_idx];
                    state_next       = (cfg_arr[arb_idx] == cfg_reg) ? XFER : WAIT_IDLE;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_IDLE: begin
                // Frame format may only move while nothing is shifting or buffered.
                if (uart_tx_idle_i) begin
                    cfg_next   = cfg_latched_reg;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                state_next = XFER;
            end
            XFER: begin
                uart_in_vld_o      = req_vld_i[idx_reg];
                uart_in_dat_o      = dat_arr[idx_reg];
                req_rdy_o[idx_reg] = uart_in_rdy_i;
                if (!req_vld_i[idx_reg] || (xfer_fire && burst_last)) begin
                    state_next     = ARB;
                    grant_next     = '0;
                    burst_cnt_next = '0;
                end else if (xfer_fire) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    assign grant_o         = grant_reg;
    assign tx_en_o         = tx_en_reg;
    assign n_parity_bits_o = cfg_reg.n_parity_bits;
    assign n_stop_bits_o   = cfg_reg.n_stop_bits;
    assign n_data_bits_o   = cfg_reg.n_data_bits;

endmodule

// File: tb/tb_prmcu_uart_tx_arbiter.sv
// Directed bench for prmcu_uart_tx_arbiter (4 requesters, bursts of 2, 9-bit words).
module tb_prmcu_uart_tx_arbiter;

    localparam logic [6:0] CFG_DEF = 7'h18;   // parity 0, stop 1, data 8
    localparam logic [6:0] CFG_ALT = 7'h67;   // parity 1, stop 2, data 7

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [35:0] req_dat_i = '0;
    logic [27:0] req_cfg_i = {4{CFG_DEF}};
    logic [3:0]  req_vld_i = '0;
    logic [3:0]  req_rdy_o;
    logic [3:0]  grant_o;
    logic [8:0]  uart_in_dat_o;
    logic        uart_in_vld_o;
    logic        uart_in_rdy_i = 1'b1;
    logic        uart_tx_idle_i = 1'b1;
    logic        tx_en_o;
    logic        n_parity_bits_o;
    logic [1:0]  n_stop_bits_o;
    logic [3:0]  n_data_bits_o;
    logic [6:0]  cfg_out;

    int n_checks = 0;
    int n_fail   = 0;

    assign cfg_out = {n_parity_bits_o, n_stop_bits_o, n_data_bits_o};

    always #5 clk = ~clk;

    prmcu_uart_tx_arbiter #(
        .N_REQ     (4),
        .MAX_BURST (2),
        .DAT_W     (9)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_dat_i       (req_dat_i),
        .req_cfg_i       (req_cfg_i),
        .req_vld_i       (req_vld_i),
        .req_rdy_o       (req_rdy_o),
        .grant_o         (grant_o),
        .uart_in_dat_o   (uart_in_dat_o),
        .uart_in_vld_o   (uart_in_vld_o),
        .uart_in_rdy_i   (uart_in_rdy_i),
        .uart_tx_idle_i  (uart_tx_idle_i),
        .tx_en_o         (tx_en_o),
        .n_parity_bits_o (n_parity_bits_o),
        .n_stop_bits_o   (n_stop_bits_o),
        .n_data_bits_o   (n_data_bits_o)
    );

    always @(posedge clk) begin
        if (rst && uart_in_vld_o && uart_in_rdy_i) begin
            $display("%0t xfer grant=%b dat=%h", $time, grant_o, uart_in_dat_o);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        tick;
        settle;
        n_checks++;
        if ({grant_o, req_rdy_o, uart_in_vld_o, uart_in_dat_o} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {grant_o, req_rdy_o, uart_in_vld_o, uart_in_dat_o});
        end
        n_checks++;
        if ({tx_en_o, cfg_out} !== {1'b0, CFG_DEF}) begin
            n_fail++;
            $display("FAIL reset_cfg_txen: got %h required %h", {tx_en_o, cfg_out}, {1'b0, CFG_DEF});
        end
        rst = 1'b1;
        tick;
        settle;
        n_checks++;
        if ({tx_en_o, grant_o} !== 5'b10000) begin
            n_fail++;
            $display("FAIL txen_after_release: got %b required 10000", {tx_en_o, grant_o});
        end
    endtask

    task automatic test_same_cfg;
        req_dat_i[0 +: 9] = 9'h055;
        req_vld_i = 4'b0001;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o} !== 5'b00000) begin
            n_fail++;
            $display("FAIL same_cfg_idle: got %b required 00000", {grant_o, uart_in_vld_o});
        end
        tick;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o, req_rdy_o} !== 9'b0) begin
            n_fail++;
            $display("FAIL same_cfg_arb: got %b required 0", {grant_o, uart_in_vld_o, req_rdy_o});
        end
        tick;
        settle;
        n_checks++;
        if ({grant_o, req_rdy_o, uart_in_vld_o, uart_in_dat_o} !== {4'b0001, 4'b0001, 1'b1, 9'h055}) begin
            n_fail++;
            $display("FAIL same_cfg_word0: got %h required %h", {grant_o, req_rdy_o, uart_in_vld_o, uart_in_dat_o}, {4'b0001, 4'b0001, 1'b1, 9'h055});
        end
        tick;
        req_dat_i[0 +: 9] = 9'h0AA;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o, uart_in_dat_o} !== {4'b0001, 1'b1, 9'h0AA}) begin
            n_fail++;
            $display("FAIL same_cfg_word1: got %h required %h", {grant_o, uart_in_vld_o, uart_in_dat_o}, {4'b0001, 1'b1, 9'h0AA});
        end
        tick;
        req_dat_i[0 +: 9] = 9'h1FF;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o} !== 5'b00000) begin
            n_fail++;
            $display("FAIL same_cfg_burst_end: got %b required 00000", {grant_o, uart_in_vld_o});
        end
        tick;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o, uart_in_dat_o, cfg_out} !== {4'b0001, 1'b1, 9'h1FF, CFG_DEF}) begin
            n_fail++;
            $display("FAIL same_cfg_word2: got %h required %h", {grant_o, uart_in_vld_o, uart_in_dat_o, cfg_out}, {4'b0001, 1'b1, 9'h1FF, CFG_DEF});
        end
        tick;
        req_vld_i = 4'b0000;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o} !== 5'b00010) begin
            n_fail++;
            $display("FAIL same_cfg_vld_drop: got %b required 00010", {grant_o, uart_in_vld_o});
        end
        tick;
        tick;
        settle;
        n_checks++;
        if ({grant_o, cfg_out} !== {4'b0000, CFG_DEF}) begin
            n_fail++;
            $display("FAIL same_cfg_back_idle: got %h required %h", {grant_o, cfg_out}, {4'b0000, CFG_DEF});
        end
    endtask

    task automatic test_cfg_change;
        req_cfg_i[7 +: 7] = CFG_ALT;
        req_dat_i[9 +: 9] = 9'h123;
        uart_tx_idle_i = 1'b0;
        req_vld_i = 4'b0010;
        tick;
        tick;
        for (int i = 0; i < 20; i++) begin
            settle;
            n_checks++;
            if ({cfg_out, uart_in_vld_o, grant_o} !== {CFG_DEF, 1'b0, 4'b0010}) begin
                n_fail++;
                $display("FAIL cfg_wait_busy[%0d]: got %h required %h", i, {cfg_out, uart_in_vld_o, grant_o}, {CFG_DEF, 1'b0, 4'b0010});
            end
            tick;
        end
        uart_tx_idle_i = 1'b1;
        tick;
        settle;
        n_checks++;
        if ({cfg_out, uart_in_vld_o, grant_o} !== {CFG_ALT, 1'b0, 4'b0010}) begin
            n_fail++;
            $display("FAIL cfg_settle: got %h required %h", {cfg_out, uart_in_vld_o, grant_o}, {CFG_ALT, 1'b0, 4'b0010});
        end
        tick;
        settle;
        n_checks++;
        if ({uart_in_vld_o, uart_in_dat_o, grant_o, req_rdy_o} !== {1'b1, 9'h123, 4'b0010, 4'b0010}) begin
            n_fail++;
            $display("FAIL cfg_first_word: got %h required %h", {uart_in_vld_o, uart_in_dat_o, grant_o, req_rdy_o}, {1'b1, 9'h123, 4'b0010, 4'b0010});
        end
        tick;
        req_vld_i = 4'b0000;
        tick;
        tick;
        settle;
        n_checks++;
        if ({cfg_out, grant_o} !== {CFG_ALT, 4'b0000}) begin
            n_fail++;
            $display("FAIL cfg_retained: got %h required %h", {cfg_out, grant_o}, {CFG_ALT, 4'b0000});
        end
        req_cfg_i[7 +: 7] = CFG_DEF;
    endtask

    task automatic test_round_robin;
        logic [3:0] eg;
        int g;
        rst = 1'b0;
        settle;
        rst = 1'b1;
        req_cfg_i = {4{CFG_DEF}};
        for (int k = 0; k < 4; k++) req_dat_i[k*9 +: 9] = 9'h0A0 + 9'(k);
        req_vld_i = 4'b1111;
        tick;
        tick;
        for (int k = 0; k < 5; k++) begin
            g  = k % 4;
            eg = 4'b0001 << g;
            for (int w = 0; w < 2; w++) begin
                settle;
                n_checks++;
                if ({grant_o, req_rdy_o, uart_in_vld_o, uart_in_dat_o} !== {eg, eg, 1'b1, 9'h0A0 + 9'(g)}) begin
                    n_fail++;
                    $display("FAIL rr_turn%0d_word%0d: got %h required %h", k, w, {grant_o, req_rdy_o, uart_in_vld_o, uart_in_dat_o}, {eg, eg, 1'b1, 9'h0A0 + 9'(g)});
                end
                tick;
            end
            settle;
            n_checks++;
            if (grant_o !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_rearb%0d: got %b required 0000", k, grant_o);
            end
            if (k == 4) req_vld_i = 4'b0000;
            tick;
        end
    endtask

    task automatic test_rdy_stall;
        req_dat_i[27 +: 9] = 9'h0C3;
        uart_in_rdy_i = 1'b0;
        req_vld_i = 4'b1000;
        tick;
        tick;
        for (int i = 0; i < 10; i++) begin
            settle;
            n_checks++;
            if ({grant_o, req_rdy_o, uart_in_vld_o, uart_in_dat_o} !== {4'b1000, 4'b0000, 1'b1, 9'h0C3}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h required %h", i, {grant_o, req_rdy_o, uart_in_vld_o, uart_in_dat_o}, {4'b1000, 4'b0000, 1'b1, 9'h0C3});
            end
            tick;
        end
        uart_in_rdy_i = 1'b1;
        settle;
        n_checks++;
        if (req_rdy_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL stall_release_rdy: got %b required 1000", req_rdy_o);
        end
        tick;
        req_dat_i[27 +: 9] = 9'h03C;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o, uart_in_dat_o} !== {4'b1000, 1'b1, 9'h03C}) begin
            n_fail++;
            $display("FAIL stall_count_kept: got %h required %h", {grant_o, uart_in_vld_o, uart_in_dat_o}, {4'b1000, 1'b1, 9'h03C});
        end
        tick;
        settle;
        n_checks++;
        if (grant_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL stall_burst_end: got %b required 0000", grant_o);
        end
        req_vld_i = 4'b0000;
        tick;
    endtask

    task automatic test_drop_vld;
        req_dat_i[18 +: 9] = 9'h022;
        req_dat_i[27 +: 9] = 9'h033;
        req_vld_i = 4'b1100;
        tick;
        tick;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o, uart_in_dat_o} !== {4'b0100, 1'b1, 9'h022}) begin
            n_fail++;
            $display("FAIL drop_first_grant: got %h required %h", {grant_o, uart_in_vld_o, uart_in_dat_o}, {4'b0100, 1'b1, 9'h022});
        end
        tick;
        req_vld_i[2] = 1'b0;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o} !== 5'b01000) begin
            n_fail++;
            $display("FAIL drop_vld_low: got %b required 01000", {grant_o, uart_in_vld_o});
        end
        tick;
        settle;
        n_checks++;
        if (grant_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL drop_rearb: got %b required 0000", grant_o);
        end
        tick;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o, uart_in_dat_o} !== {4'b1000, 1'b1, 9'h033}) begin
            n_fail++;
            $display("FAIL drop_next_grant: got %h required %h", {grant_o, uart_in_vld_o, uart_in_dat_o}, {4'b1000, 1'b1, 9'h033});
        end
        req_vld_i = 4'b0000;
        tick;
        tick;
    endtask

    task automatic test_reset_mid_xfer;
        req_dat_i[0 +: 9] = 9'h100;
        req_dat_i[9 +: 9] = 9'h111;
        req_cfg_i[7 +: 7] = CFG_ALT;
        uart_in_rdy_i = 1'b0;
        req_vld_i = 4'b0010;
        tick;
        tick;
        tick;
        tick;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o, uart_in_dat_o, cfg_out} !== {4'b0010, 1'b1, 9'h111, CFG_ALT}) begin
            n_fail++;
            $display("FAIL midrst_pre_xfer: got %h required %h", {grant_o, uart_in_vld_o, uart_in_dat_o, cfg_out}, {4'b0010, 1'b1, 9'h111, CFG_ALT});
        end
        rst = 1'b0;
        settle;
        n_checks++;
        if ({grant_o, req_rdy_o, uart_in_vld_o, uart_in_dat_o, tx_en_o, cfg_out} !== {4'b0, 4'b0, 1'b0, 9'h0, 1'b0, CFG_DEF}) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h required %h", {grant_o, req_rdy_o, uart_in_vld_o, uart_in_dat_o, tx_en_o, cfg_out}, {4'b0, 4'b0, 1'b0, 9'h0, 1'b0, CFG_DEF});
        end
        req_cfg_i[7 +: 7] = CFG_DEF;
        req_vld_i = 4'b0011;
        uart_in_rdy_i = 1'b1;
        rst = 1'b1;
        tick;
        settle;
        n_checks++;
        if ({tx_en_o, grant_o} !== 5'b10000) begin
            n_fail++;
            $display("FAIL midrst_arb: got %b required 10000", {tx_en_o, grant_o});
        end
        tick;
        settle;
        n_checks++;
        if ({grant_o, uart_in_vld_o, uart_in_dat_o} !== {4'b0001, 1'b1, 9'h100}) begin
            n_fail++;
            $display("FAIL midrst_first_winner: got %h required %h", {grant_o, uart_in_vld_o, uart_in_dat_o}, {4'b0001, 1'b1, 9'h100});
        end
        req_vld_i = 4'b0000;
        tick;
        tick;
    endtask

    initial begin
        test_reset;
        test_same_cfg;
        test_cfg_change;
        test_round_robin;
        test_rdy_stall;
        test_drop_vld;
        test_reset_mid_xfer;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/prmcu_uart_tx_arbiter.md
Name: prmcu_uart_tx_arbiter

Overview:
Shares the single UART transmitter path of prmcu_uart_top among N_REQ requesters, each with its own frame format (parity, stop bits, data bits). Round-robin arbitration with bounded bursts. Reprograms the UART frame configuration only while the transmitter is idle. Sits between on-chip requesters and the in_dat/in_vld/in_rdy and n_*_bits inputs of prmcu_uart_top.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_BURST, 8, max words accepted per grant before re-arbitration (1..255)
DAT_W, 9, word width, matches UART in_dat

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted at 0)
req_dat_i  in  N_REQ*DAT_W  requester data, slice k = requester k
req_cfg_i  in  N_REQ*7  per-requester cfg {parity[6], stop[5:4], data_bits[3:0]}
req_vld_i  in  N_REQ  requester word valid
req_rdy_o  out  N_REQ  requester word accepted
grant_o  out  N_REQ  one-hot current owner, 0 when none
uart_in_dat_o  out  DAT_W  to UART in_dat_i
uart_in_vld_o  out  1  to UART in_vld_i
uart_in_rdy_i  in  1  from UART in_rdy_o
uart_tx_idle_i  in  1  UART transmitter idle (no frame shifting, nothing buffered)
tx_en_o  out  1  to UART tx_en
n_parity_bits_o  out  1  to UART n_parity_bits_i
n_stop_bits_o  out  2  to UART n_stop_bits_i
n_data_bits_o  out  4  to UART n_data_bits_i

Behaviour:
- Reset (rst=0, async): state IDLE; grant_o=0, req_rdy_o=0, uart_in_vld_o=0, uart_in_dat_o=0, tx_en_o=0; cfg outputs = parity 0, stop 1, data 8; rr pointer = N_REQ-1 (requester 0 wins first); burst count 0.
- tx_en_o = 1 in every cycle after the first clock edge following reset release.
- Handshake: valid/ready; transfer when vld&rdy high on a rising clk edge; requesters hold dat and vld stable until accepted.
- States:
  IDLE: no grant. Any req_vld_i high -> ARB next cycle.
  ARB (1 cycle): pick the first requester with vld high, searching from rr pointer+1 with wrap-around; register grant, latch its req_cfg_i into cfg_latched, set rr pointer = winner. If no vld is high (withdrawn) -> IDLE. If cfg_latched equals current cfg outputs -> XFER, else -> WAIT_IDLE.
  WAIT_IDLE: uart_in_vld_o=0. When uart_tx_idle_i=1, drive cfg outputs = cfg_latched -> SETTLE.
  SETTLE (1 cycle): cfg stable, no transfer -> XFER.
  XFER: uart_in_dat_o/uart_in_vld_o combinationally follow the granted requester; req_rdy_o[g] = uart_in_rdy_i; other rdy bits 0. Each transfer increments burst count. Leave to ARB (count cleared) when count reaches MAX_BURST on a transfer, or in any cycle where req_vld_i[g]=0.
- Cfg outputs change only in WAIT_IDLE with uart_tx_idle_i=1; never while a frame is in flight.
- req_cfg_i changes while granted are ignored until the next ARB.
- grant_o is stable from ARB exit to XFER exit; zero in IDLE and ARB.
- Zero added latency in XFER; arbitration overhead 1 cycle (same cfg) or 2 cycles plus idle wait (cfg change).
- Reset mid-XFER: all outputs return to reset values immediately; any partially offered word is not counted as accepted.
- Requester data is passed unmodified; masking to n_data_bits is the UART's job.

Decomposition:
- prmcu_uart_pkg: uart_cfg_t packed struct {n_parity_bits, n_stop_bits[1:0], n_data_bits[3:0]}, CFG_RESET constant (0,1,8), arb_state_t enum {IDLE, ARB, WAIT_IDLE, SETTLE, XFER}.
- Sub-module prmcu_rr_arbiter: combinational round-robin pick (req vector, pointer -> one-hot winner, any).

Test Plan:
- Single requester 0, cfg = reset cfg, 3 words 0x055,0x0AA,0x1FF -> ARB then XFER, no WAIT_IDLE; words appear on uart_in_dat_o in order; grant_o=0001.
- Requester 1 with cfg parity 1, stop 2, data 7 while uart_tx_idle_i=0 for 20 cycles -> cfg outputs unchanged, uart_in_vld_o=0 until idle rises; cfg updates, 1 SETTLE cycle, then first word offered.
- Requesters 0..3 all continuously valid, MAX_BURST=2 -> grant sequence 0,1,2,3,0 with exactly 2 transfers each.
- uart_in_rdy_i held low 10 cycles during XFER -> vld and dat held, req_rdy_o[g]=0, burst count unchanged, no grant change.
- Requester 2 drops vld after 1 of MAX_BURST words while requester 3 valid -> re-arbitration, grant_o=1000 next.
- rst asserted mid-XFER with vld high -> all outputs immediately at reset values; after release, requester 0 wins first.
